// File: rtl/clk_div_bank_pkg.sv
// Shared constants and types for the clock divider bank.
//   DEF_NUM_CH / DEF_CNT_W / DEF_LOCK_CYCLES : default top-level parameters
//   MIN_RATIO  : smallest divide ratio a channel will run at; smaller requests are raised to it
//   ch_state_e : per-channel run state
//     STOP     : idle, outputs low, ratio tracks the input continuously
//     RUN      : enabled and dividing
//     STOPPING : enable has dropped, finishing the current period
package clk_div_bank_pkg;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_LOCK_CYCLES = 16;
  localparam int MIN_RATIO       = 2;

  typedef enum logic [1:0] {
    STOP     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } ch_state_e;

endpackage

// File: rtl/clk_div_ch.sv
// One divided-clock channel.
// Ports:
//   clk     : source clock, rising edge
//   rst     : asynchronous active-high reset
//   en      : run enable
//   div     : requested divide ratio (values below MIN_RATIO are raised to it)
//   div_clk : registered divided clock, high for the first ceil(ratio/2) counts
//   stb     : high for the first count of every period
//   locked  : (only when CLK_DIV_BANK_LOCK_EN is defined) one full period has
//             completed at the ratio currently in use
// The ratio is captured only when a period starts, so a mid-period change of
// div never shortens or stretches the period in flight. Dropping en lets the
// current period finish; raising it again before the period ends cancels the stop.
module clk_div_ch
  import clk_div_bank_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div,
  output logic             div_clk,
  output logic             stb
`ifdef CLK_DIV_BANK_LOCK_EN
  ,
  output logic             locked
`endif
);

  localparam logic [CNT_W-1:0] MIN_DS = CNT_W'(MIN_RATIO);

  // All channel state in one struct so it can be probed as a unit.
  typedef struct packed {
    ch_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] ds;
  } ch_regs_t;

  ch_regs_t         cur;
  ch_regs_t         nxt;
  logic             nxt_clk;
  logic             nxt_stb;
  logic [CNT_W-1:0] div_c;
  logic [CNT_W-1:0] high_len;
  logic             boundary;

  assign div_c    = (div < MIN_DS) ? MIN_DS : div;
  // ceil(ds/2) without the overflow that ds+1 would hit at the top of the range
  assign high_len = (cur.ds >> 1) + {{(CNT_W-1){1'b0}}, cur.ds[0]};
  assign boundary = (cur.cnt == cur.ds - 1'b1);

  always_comb begin
    nxt     = cur;
    nxt_clk = 1'b0;
    nxt_stb = 1'b0;
    case (cur.state)
      STOP: begin
        nxt.cnt = '0;
        nxt.ds  = div_c;
        if (en) begin
          nxt.state = RUN;
          nxt_clk   = 1'b1;
          nxt_stb   = 1'b1;
        end
      end
      default: begin
        if (boundary) begin
          nxt.cnt = '0;
          nxt.ds  = div_c;
          if (en) begin
            nxt.state = RUN;
            nxt_clk   = 1'b1;
            nxt_stb   = 1'b1;
          end else begin
            nxt.state = STOP;
          end
        end else begin
          nxt.cnt   = cur.cnt + 1'b1;
          nxt.state = en ? RUN : STOPPING;
          nxt_clk   = (nxt.cnt < high_len);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur.state <= STOP;
      cur.cnt   <= '0;
      cur.ds    <= MIN_DS;
      div_clk   <= 1'b0;
      stb       <= 1'b0;
    end else begin
      cur     <= nxt;
      div_clk <= nxt_clk;
      stb     <= nxt_stb;
    end
  end

`ifdef CLK_DIV_BANK_LOCK_EN
  // Lock sets when a period ends and the next one reuses the same ratio;
  // starting, stopping or switching ratio all clear it.
  logic nxt_locked;

  always_comb begin
    nxt_locked = locked;
    if (cur.state == STOP) begin
      nxt_locked = 1'b0;
    end else if (boundary) begin
      nxt_locked = en && (div_c == cur.ds);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked <= 1'b0;
    end else begin
      locked <= nxt_locked;
    end
  end
`endif

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH independent clock dividers on one source clock.
// Ports:
//   sysClk_i   : source clock, all logic on its rising edge
//   RESET_i    : asynchronous active-high reset
//   chEn_i     : per-channel run enable
//   div_i      : per-channel divide ratio, channel n at [n*CNT_W +: CNT_W]
//   clk_o      : per-channel registered divided clock
//   stb_o      : per-channel one-cycle period-start strobe
//   chLocked_o : per-channel stable indication
//   locked_o   : bank-wide lock
// Build option CLK_DIV_BANK_LOCK_EN: when defined, lock tracks a post-reset
// settle counter and per-channel period stability; when undefined, both lock
// outputs simply go high on the first clock edge after reset.
module clk_div_bank
  import clk_div_bank_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic                    sysClk_i,
  input  logic                    RESET_i,
  input  logic [NUM_CH-1:0]       chEn_i,
  input  logic [NUM_CH*CNT_W-1:0] div_i,
  output logic [NUM_CH-1:0]       clk_o,
  output logic [NUM_CH-1:0]       stb_o,
  output logic [NUM_CH-1:0]       chLocked_o,
  output logic                    locked_o
);

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    clk_div_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk    (sysClk_i),
      .rst    (RESET_i),
      .en     (chEn_i[n]),
      .div    (div_i[n*CNT_W +: CNT_W]),
      .div_clk(clk_o[n]),
      .stb    (stb_o[n])
`ifdef CLK_DIV_BANK_LOCK_EN
      ,
      .locked (chLocked_o[n])
`endif
    );
  end

`ifdef CLK_DIV_BANK_LOCK_EN
  localparam int LW = (LOCK_CYCLES < 1) ? 1 : $clog2(LOCK_CYCLES + 1);

  logic [LW-1:0] lock_cnt;
  logic          lock_done;

  assign lock_done = (lock_cnt == LW'(LOCK_CYCLES));

  always_ff @(posedge sysClk_i or posedge RESET_i) begin
    if (RESET_i) begin
      lock_cnt <= '0;
    end else if (!lock_done) begin
      lock_cnt <= lock_cnt + 1'b1;
    end
  end

  // Disabled channels are ignored; with nothing enabled the bank is not locked.
  assign locked_o = lock_done && (|chEn_i) && (&(chLocked_o | ~chEn_i));
`else
  logic up;

  always_ff @(posedge sysClk_i or posedge RESET_i) begin
    if (RESET_i) begin
      up <= 1'b0;
    end else begin
      up <= 1'b1;
    end
  end

  assign chLocked_o = {NUM_CH{up}};
  assign locked_o   = up;
`endif

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: directed scenarios with literal
// expectations plus randomized enables/ratios checked every cycle against a
// period-based model of the channels.
module tb_clk_div_bank;

  localparam int NUM_CH      = 4;
  localparam int CNT_W       = 8;
  localparam int LOCK_CYCLES = 16;
`ifdef CLK_DIV_BANK_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  // clock / reset
  logic                    sysClk_i = 1'b0;
  logic                    RESET_i  = 1'b1;
  logic [NUM_CH-1:0]       chEn_i   = '0;
  logic [NUM_CH*CNT_W-1:0] div_i    = '0;
  logic [NUM_CH-1:0]       clk_o;
  logic [NUM_CH-1:0]       stb_o;
  logic [NUM_CH-1:0]       chLocked_o;
  logic                    locked_o;

  always #5 sysClk_i = ~sysClk_i;

  clk_div_bank #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .sysClk_i  (sysClk_i),
    .RESET_i   (RESET_i),
    .chEn_i    (chEn_i),
    .div_i     (div_i),
    .clk_o     (clk_o),
    .stb_o     (stb_o),
    .chLocked_o(chLocked_o),
    .locked_o  (locked_o)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic chk1(input string name, input logic act, input logic req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s actual=%b required=%b t=%0t", name, act, req, $time);
  endtask

  task automatic chk4(input string name, input logic [NUM_CH-1:0] act, input logic [NUM_CH-1:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
  endtask

  // Model: each running channel sits at some age within a period of known length.
  int m_run [NUM_CH];
  int m_age [NUM_CH];
  int m_per [NUM_CH];
  int m_lk  [NUM_CH];
  int m_cyc = 0;
  int m_up  = 0;

  function automatic int ratio(input int n);
    int d;
    d = int'(div_i[n*CNT_W +: CNT_W]);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic model_step();
    int np;
    if (RESET_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_run[i] = 0; m_age[i] = 0; m_per[i] = 2; m_lk[i] = 0;
      end
      m_cyc = 0;
      m_up  = 0;
    end else begin
      if (m_cyc < LOCK_CYCLES) m_cyc++;
      m_up = 1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (m_run[i] == 0) begin
          m_lk[i] = 0;
          if (chEn_i[i]) begin
            m_run[i] = 1; m_age[i] = 0; m_per[i] = ratio(i);
          end
        end else if (m_age[i] == m_per[i] - 1) begin
          if (!chEn_i[i]) begin
            m_run[i] = 0; m_lk[i] = 0;
          end else begin
            np = ratio(i);
            m_lk[i]  = (np == m_per[i]) ? 1 : 0;
            m_per[i] = np;
            m_age[i] = 0;
          end
        end else begin
          m_age[i]++;
        end
      end
    end
  endtask

  task automatic model_out(output logic [NUM_CH-1:0] e_clk, output logic [NUM_CH-1:0] e_stb,
                           output logic [NUM_CH-1:0] e_lk, output logic e_locked);
    bit any_en;
    bit all_ok;
    any_en = 1'b0;
    all_ok = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      e_clk[i] = (m_run[i] != 0) && (m_age[i] < (m_per[i] + 1) / 2);
      e_stb[i] = (m_run[i] != 0) && (m_age[i] == 0);
`ifdef CLK_DIV_BANK_LOCK_EN
      e_lk[i] = (m_lk[i] != 0);
`else
      e_lk[i] = (m_up != 0);
`endif
      if (chEn_i[i]) begin
        any_en = 1'b1;
        if (!e_lk[i]) all_ok = 1'b0;
      end
    end
`ifdef CLK_DIV_BANK_LOCK_EN
    e_locked = (m_cyc >= LOCK_CYCLES) && any_en && all_ok;
`else
    e_locked = (m_up != 0);
`endif
    if (RESET_i) begin
      e_clk = '0; e_stb = '0; e_lk = '0; e_locked = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge sysClk_i);
    model_step();
  end

  // scoreboard: every falling edge
  initial forever begin
    logic [NUM_CH-1:0] ec, es, el;
    logic              elk;
    @(negedge sysClk_i);
    model_out(ec, es, el, elk);
    chk4("cyc_clk_o", clk_o, ec);
    chk4("cyc_stb_o", stb_o, es);
    chk4("cyc_chLocked_o", chLocked_o, el);
    chk1("cyc_locked_o", locked_o, elk);
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge sysClk_i);
    #1;
  endtask

  task automatic set_div(input int ch, input int d);
    div_i[ch*CNT_W +: CNT_W] = CNT_W'(d);
  endtask

  initial begin
    tick(2);
    chk4("rst_clk_o", clk_o, 4'h0);
    chk4("rst_stb_o", stb_o, 4'h0);
    chk4("rst_chLocked_o", chLocked_o, 4'h0);
    chk1("rst_locked_o", locked_o, 1'b0);
    RESET_i = 1'b0;
    #1;
    chk1("release_locked_o", locked_o, 1'b0);
    tick(1);
    chk4("first_edge_chLocked_o", chLocked_o, LOCK_EN ? 4'h0 : 4'hF);
    chk1("first_edge_locked_o", locked_o, LOCK_EN ? 1'b0 : 1'b1);
    chk4("first_edge_clk_o", clk_o, 4'h0);

    // ch0 ratio 10
    set_div(0, 10); chEn_i[0] = 1'b1;
    tick(1);
    chk1("ch0_start_clk", clk_o[0], 1'b1);
    chk1("ch0_start_stb", stb_o[0], 1'b1);
    tick(4); chk1("ch0_cnt4_clk", clk_o[0], 1'b1);
    tick(1); chk1("ch0_cnt5_clk", clk_o[0], 1'b0);
    tick(4); chk1("ch0_cnt9_stb", stb_o[0], 1'b0);
    chk1("ch0_cnt9_lock", chLocked_o[0], LOCK_EN ? 1'b0 : 1'b1);
    tick(1); chk1("ch0_wrap_stb", stb_o[0], 1'b1);
    chk1("ch0_wrap_clk", clk_o[0], 1'b1);
    chk1("ch0_wrap_lock", chLocked_o[0], 1'b1);
    tick(10); chk1("ch0_wrap2_stb", stb_o[0], 1'b1);
    chk1("ch0_bank_locked", locked_o, 1'b1);

    // ch1 ratio 5 then 1 then 0
    set_div(1, 5); chEn_i[1] = 1'b1;
    tick(1); chk1("ch1_start_stb", stb_o[1], 1'b1);
    chk1("ch1_start_bank_locked", locked_o, LOCK_EN ? 1'b0 : 1'b1);
    tick(2); chk1("ch1_cnt2_clk", clk_o[1], 1'b1);
    tick(1); chk1("ch1_cnt3_clk", clk_o[1], 1'b0);
    tick(2); chk1("ch1_wrap_stb", stb_o[1], 1'b1);
    set_div(1, 1);
    tick(3); chk1("ch1_old_period_clk", clk_o[1], 1'b0);
    chk1("ch1_old_period_stb", stb_o[1], 1'b0);
    tick(2); chk1("ch1_d1_stb", stb_o[1], 1'b1);
    chk1("ch1_d1_lock_drop", chLocked_o[1], LOCK_EN ? 1'b0 : 1'b1);
    tick(1); chk1("ch1_d1_low", clk_o[1], 1'b0);
    tick(1); chk1("ch1_d1_stb2", stb_o[1], 1'b1);
    chk1("ch1_d1_relock", chLocked_o[1], 1'b1);
    set_div(1, 0);
    tick(2); chk1("ch1_d0_stb", stb_o[1], 1'b1);
    chk1("ch1_d0_lock", chLocked_o[1], 1'b1);

    // ch2 ratio 4 -> 6 at count 1
    set_div(2, 4); chEn_i[2] = 1'b1;
    tick(1); chk1("ch2_start_stb", stb_o[2], 1'b1);
    tick(4); chk1("ch2_lock", chLocked_o[2], 1'b1);
    tick(1); set_div(2, 6);
    tick(2); chk1("ch2_cnt3_clk", clk_o[2], 1'b0);
    chk1("ch2_cnt3_stb", stb_o[2], 1'b0);
    tick(1); chk1("ch2_change_stb", stb_o[2], 1'b1);
    chk1("ch2_change_lock", chLocked_o[2], LOCK_EN ? 1'b0 : 1'b1);
    tick(5); chk1("ch2_d6_cnt5_clk", clk_o[2], 1'b0);
    tick(1); chk1("ch2_d6_stb", stb_o[2], 1'b1);
    chk1("ch2_relock", chLocked_o[2], 1'b1);

    // ch3 ratio 8, stop during high phase
    set_div(3, 8); chEn_i[3] = 1'b1;
    tick(1); chk1("ch3_start_stb", stb_o[3], 1'b1);
    tick(1); chEn_i[3] = 1'b0;
    tick(2); chk1("ch3_stopping_clk", clk_o[3], 1'b1);
    tick(4); chk1("ch3_cnt7_clk", clk_o[3], 1'b0);
    tick(1); chk1("ch3_stopped_clk", clk_o[3], 1'b0);
    chk1("ch3_stopped_stb", stb_o[3], 1'b0);
    chk1("ch3_stopped_lock", chLocked_o[3], LOCK_EN ? 1'b0 : 1'b1);
    tick(3); chk1("ch3_idle_clk", clk_o[3], 1'b0);
    chEn_i[3] = 1'b1;
    tick(1); chk1("ch3_restart_clk", clk_o[3], 1'b1);
    chk1("ch3_restart_stb", stb_o[3], 1'b1);
    // cancelled stop
    tick(1); chEn_i[3] = 1'b0;
    tick(2); chEn_i[3] = 1'b1;
    tick(5); chk1("ch3_cancel_stb", stb_o[3], 1'b1);
    chk1("ch3_cancel_clk", clk_o[3], 1'b1);

    // randomized enables and ratios
    repeat (600) begin
      tick(1);
      if ($urandom_range(0, 15) == 0) chEn_i[$urandom_range(0, NUM_CH-1)] ^= 1'b1;
      if ($urandom_range(0, 7) == 0) set_div(int'($urandom_range(0, NUM_CH-1)), int'($urandom_range(0, 12)));
    end

    // asynchronous reset mid-period with everything running
    set_div(0, 10); set_div(1, 5); set_div(2, 6); set_div(3, 8);
    chEn_i = '1;
    tick(30);
    #2;
    RESET_i = 1'b1;
    #1;
    chk4("async_rst_clk_o", clk_o, 4'h0);
    chk4("async_rst_stb_o", stb_o, 4'h0);
    chk4("async_rst_chLocked_o", chLocked_o, 4'h0);
    chk1("async_rst_locked_o", locked_o, 1'b0);
    tick(2);
    RESET_i = 1'b0;
    tick(1);
    chk4("post_rst_start_stb", stb_o, 4'hF);
    chk1("post_rst_edge1_locked", locked_o, LOCK_EN ? 1'b0 : 1'b1);
    chk4("post_rst_edge1_chLocked", chLocked_o, LOCK_EN ? 4'h0 : 4'hF);
    tick(14);
    chk1("post_rst_edge15_locked", locked_o, LOCK_EN ? 1'b0 : 1'b1);
    tick(1);
    chk1("post_rst_edge16_locked", locked_o, 1'b1);
    tick(5);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
